// File: rtl/fdiv_iter.sv
// IEEE-754 single-precision divider: one restoring quotient bit per cycle,
// round-to-nearest-even, denormal inputs and outputs flushed to signed zero.
module fdiv_iter #(
  parameter int ITER = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  // Quotient bits below the round bit (only when ITER > 26) fold into sticky.
  localparam logic [ITER-1:0] LOW_MASK = ITER'((64'd1 << (ITER - 26)) - 64'd1);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [24:0]           rem_q, rem_d;
  logic [23:0]           mb_q, mb_d;
  logic [ITER-1:0]       quo_q, quo_d;
  logic signed [9:0]     exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic [31:0]           y_q, y_d;

  logic [7:0]            ea, eb;
  logic [23:0]           ma, mb;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
  logic signed [9:0]     exp_raw;
  logic                  q_bit, sticky;
  logic [24:0]           rem_sub;

  function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                             input logic [23:0] m, input logic g,
                                             input logic r, input logic st);
    logic [24:0]       mr;
    logic signed [9:0] ef;
    mr = {1'b0, m} + {24'd0, g & (r | st | m[0])};
    ef = e;
    if (mr[24]) begin
      mr = 25'h080_0000;
      ef = e + 10'sd1;
    end
    // A normal result must carry its hidden bit.
    if (ef >= 10'sd255)              round_pack = {s, 8'hFF, 23'd0};
    else if (ef <= 10'sd0 || !mr[23]) round_pack = {s, 31'd0};
    else                             round_pack = {s, ef[7:0], mr[22:0]};
  endfunction

  assign ea      = a[30:23];
  assign eb      = b[30:23];
  assign ma      = {1'b1, a[22:0]};
  assign mb      = {1'b1, b[22:0]};
  assign a_zero  = (ea == 8'd0);
  assign b_zero  = (eb == 8'd0);
  assign a_inf   = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign sgn     = a[31] ^ b[31];
  assign exp_raw = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

  assign q_bit   = (rem_q >= {1'b0, mb_q});
  assign rem_sub = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
  assign sticky  = (rem_q != 25'd0) | (|(quo_q & LOW_MASK));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mb_d    = mb_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sgn;
          state_d = DONE;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            y_d = QNAN;
          end else if (b_zero || a_inf) begin
            y_d = {sgn, 8'hFF, 23'd0};
          end else if (a_zero || b_inf) begin
            y_d = {sgn, 31'd0};
          end else begin
            state_d = DIV;
            mb_d    = mb;
            quo_d   = '0;
            cnt_d   = CNT_W'(ITER);
            // Pre-normalise so the first quotient bit is always 1.
            if (ma < mb) begin
              rem_d = {ma, 1'b0};
              exp_d = exp_raw - 10'sd1;
            end else begin
              rem_d = {1'b0, ma};
              exp_d = exp_raw;
            end
          end
        end
      end
      DIV: begin
        if (cnt_q == '0) begin
          state_d = ROUND;
        end else begin
          quo_d = {quo_q[ITER-2:0], q_bit};
          rem_d = {rem_sub[23:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ROUND: begin
        y_d     = round_pack(sign_q, exp_q, quo_q[ITER-1 -: 24], quo_q[ITER-25],
                             quo_q[ITER-26], sticky);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      mb_q    <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      mb_q    <= mb_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Randomised bench for fdiv_iter against an integer long-division reference
// with exact round-to-nearest-even.
module tb_fdiv_iter;
  localparam int ITER = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int n_tests = 0;
  int n_fail  = 0;

  fdiv_iter #(.ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  function automatic bit is_special(input logic [31:0] x);
    return (x[30:23] == 8'd0) || (x[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] d);
    int ex, ed, e, sh;
    logic s;
    bit xz, dz, xi, di, xn, dn, up;
    longint unsigned mx, md, q, r, mant, lost, half;
    ex = int'(x[30:23]);
    ed = int'(d[30:23]);
    s  = x[31] ^ d[31];
    xz = (ex == 0);
    dz = (ed == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    di = (ed == 255) && (d[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    dn = (ed == 255) && (d[22:0] != 0);
    if (xn || dn || (xz && dz) || (xi && di)) return 32'h7FC0_0000;
    if (dz || xi) return {s, 8'hFF, 23'd0};
    if (xz || di) return {s, 31'd0};
    mx = 64'({1'b1, x[22:0]});
    md = 64'({1'b1, d[22:0]});
    q  = (mx << 32) / md;
    r  = (mx << 32) % md;
    e  = ex - ed + 127;
    if (q >= (64'd1 << 32)) sh = 9;
    else begin
      sh = 8;
      e  = e - 1;
    end
    mant = q >> sh;
    lost = q & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    up   = (lost > half) || (lost == half && (r != 0 || mant[0]));
    if (up) mant = mant + 64'd1;
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    int sel;
    logic [7:0] ex;
    sel = $urandom_range(0, 15);
    case (sel)
      0:       ex = 8'd0;
      1:       ex = 8'hFF;
      2, 3:    ex = 8'($urandom_range(1, 254));
      default: ex = 8'($urandom_range(100, 154));
    endcase
    if (sel == 1 && $urandom_range(0, 1) == 0) return {1'($urandom), ex, 23'd0};
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  // Starts at posedge+1; leaves the block back in IDLE at posedge+1.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int hold);
    logic [31:0] exp_y;
    int lat, exp_lat;
    exp_y   = ref_div(av, bv);
    exp_lat = (is_special(av) || is_special(bv)) ? 0 : ITER + 2;
    a = av;
    b = bv;
    in_valid = 1'b1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("y", y, exp_y);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_y", y, exp_y);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    chk("in_ready_handshake", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_valid", 32'(out_valid), 32'd0);
    chk("after_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_y", y, 32'd0);

    run_op(32'h3F80_0000, 32'h4000_0000, 0);
    run_op(32'h3F80_0000, 32'h4040_0000, 0);
    run_op(32'h3F80_0000, 32'h0000_0000, 0);
    run_op(32'h0000_0000, 32'h0000_0000, 0);
    run_op(32'h0080_0000, 32'h4000_0000, 0);
    run_op(32'h7F00_0000, 32'h3E80_0000, 0);
    run_op(32'hFF80_0000, 32'h3F80_0000, 0);
    run_op(32'h8000_0000, 32'h7F80_0000, 0);
    run_op(32'h7F80_0000, 32'hFF80_0000, 0);
    run_op(32'h7FC1_2345, 32'h3F80_0000, 0);
    run_op(32'hC0A0_0000, 32'h4040_0000, 10);

    // Reset in the middle of DIV discards the operation.
    a = 32'h4000_0000;
    b = 32'h4040_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("middiv_in_ready", 32'(in_ready), 32'd1);
    chk("middiv_y", y, 32'd0);
    quiet = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) quiet++;
    end
    chk("middiv_no_valid", 32'(quiet), 32'd0);
    run_op(32'h3F80_0000, 32'h4080_0000, 0);

    // Reset wins over a simultaneous accept.
    a = 32'h3F80_0000;
    b = 32'h4000_0000;
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_prio_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_prio_out_valid", 32'(out_valid), 32'd0);

    for (int n = 0; n < 200; n++) begin
      run_op(rand_operand(), rand_operand(), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fdiv_iter.md
FDIV_ITER -- requirements
Module: fdiv_iter

Interface
REQ-001 SHALL have parameter ITER, default 26, giving the number of quotient bits generated: 24 mantissa bits, 1 guard bit, 1 round bit.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the a/b operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-006 SHALL have port a, input, 32 bits: IEEE-754 single-precision dividend.
REQ-007 SHALL have port b, input, 32 bits: IEEE-754 single-precision divisor.
REQ-008 SHALL have port out_valid, output, 1 bit: y holds the result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes y.
REQ-010 SHALL have port y, output, 32 bits: a/b, rounded to nearest even; this is the exact reference the finv accuracy sweeps compare against.

Function
REQ-011 SHALL implement states IDLE, DIV, ROUND, DONE; in_ready = 1 only in IDLE.
REQ-012 SHALL accept operands when in_valid & in_ready at an edge, latching a and b internally; later changes on a/b SHALL NOT affect the result.
REQ-013 SHALL treat an input with exponent 0 as signed zero (denormal flush); exponent 255 with mantissa 0 is inf, with mantissa non-zero is NaN.
REQ-014 SHALL resolve special cases at accept, going IDLE->DONE directly (out_valid one cycle after accept):
- NaN operand, 0/0, or inf/inf -> 0x7FC00000
- finite/0 or inf/finite -> signed inf
- 0/finite or finite/inf -> signed zero
REQ-015 SHALL set sign = a[31]^b[31] for all non-NaN results.
REQ-016 For normal operands, SHALL form ma = {1,a[22:0]} and mb = {1,b[22:0]} (24 bits), with exponent e = ea - eb + 127 in a signed 10-bit field.
REQ-017 If ma < mb, SHALL double the partial remainder and decrement e by 1 before iteration.
REQ-018 SHALL, in DIV, generate one quotient bit per cycle by restoring division for exactly ITER cycles, counted by a down-counter; DIV->ROUND when the counter reaches 0.
REQ-019 SHALL set sticky = (final remainder != 0).
REQ-020 SHALL round in ROUND (one cycle) to nearest even from guard, round and sticky.
REQ-021 On rounding overflow (mantissa 0x1000000), SHALL set the mantissa to 0x800000 and increment e.
REQ-022 After rounding, SHALL map e >= 255 to signed inf and e <= 0 to signed zero (no denormal output).
REQ-023 SHALL hold y stable with out_valid = 1 in DONE until out_ready = 1, then go DONE->IDLE on that edge.
REQ-024 in_ready SHALL be 0 in the cycle out_valid & out_ready; a new accept is possible the following cycle earliest.
REQ-025 Latency SHALL be fixed: for a normal path accepted at edge k, out_valid first = 1 after edge k+ITER+2 (k+28 default).
REQ-026 in_valid outside IDLE SHALL be ignored (no queueing).

Reset
REQ-027 When rst = 1 at an edge, SHALL enter IDLE, with out_valid = 0, y = 0, in_ready = 1 after that edge, and iteration counter and remainder cleared.
REQ-028 Reset mid-DIV or in DONE SHALL discard the operation; no stale out_valid after the reset edge.
REQ-029 rst SHALL take priority over a simultaneous accept or out_ready.

Verification
REQ-030 a=0x3F800000, b=0x40000000 accepted at edge k -> y=0x3F000000, out_valid first seen after edge k+28.
REQ-031 a=0x3F800000, b=0x40400000 -> y=0x3EAAAAAB, exercising round-up via the sticky bit.
REQ-032 b=0x00000000 with a=0x3F800000 -> 0x7F800000; with a=0x00000000 -> 0x7FC00000; out_valid one cycle after accept.
REQ-033 a=0x00800000, b=0x40000000 -> 0x00000000 (underflow flush); a=0x7F000000, b=0x3E800000 -> 0x7F800000 (overflow).
REQ-034 out_ready held 0 for 10 cycles in DONE -> y and out_valid stable throughout; in_valid pulses during that time are not accepted.
REQ-035 rst=1 for one cycle at DIV iteration 10 -> out_valid stays 0, in_ready=1 next cycle, and the next operation (1.0/4.0) returns 0x3E800000.
